clk_div_n: RTL

// - Programmable integer clock divider; generalised successor to the fixed divide-by-4 block.
// - Produces a divided clock-enable waveform po_clk with near-50% duty cycle and a 1-cycle period-start strobe po_tick.
// - Divisor is runtime-loadable; a new value is applied only at a period boundary, so the output never glitches.
// - Sits in the clocking and timing utilities and feeds downstream logic as a data-path enable or slow clock.

---
 rtl/clk_div_n.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/clk_div_n.sv
// Programmable integer clock divider with period-boundary divisor reload.
// Optional true 50% duty for odd divisors via macro CLK_DIV_ODD_DUTY_EN.
module clk_div_n #(
    parameter int CNT_W   = 8,
    parameter int DIV_RST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             po_clk,
    output logic             po_tick,
    output logic             load_err,
    output logic             load_pend,
    output logic [CNT_W-1:0] div_cur
);

    localparam logic [CNT_W-1:0] L_DIV_RST = CNT_W'(DIV_RST);
    localparam logic [CNT_W-1:0] L_CNT_RST = CNT_W'(DIV_RST - 1);
    localparam logic [CNT_W-1:0] L_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_TWO     = CNT_W'(2);
    localparam logic [CNT_W-1:0] L_ZERO    = CNT_W'(0);

    // Number of rising-edge high cycles for divisor n.
    function automatic logic [CNT_W-1:0] f_high_len(input logic [CNT_W-1:0] n);
`ifdef CLK_DIV_ODD_DUTY_EN
        // Odd n: (n-1)>>1 equals n>>1; the falling-edge flop adds the half cycle.
        return n >> 1;
`else
        logic [CNT_W:0] w_sum;
        w_sum = {1'b0, n} + (CNT_W+1)'(1);
        return w_sum[CNT_W:1];
`endif
    endfunction

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_cur;
    logic [CNT_W-1:0] r_pend;
    logic             r_load_pend;
    logic             r_po_clk_q;
    logic             r_po_tick;
    logic             r_load_err;

    logic             w_wrap;
    logic             w_apply;
    logic [CNT_W-1:0] w_div_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] w_high;
    logic             w_load_ok;
    logic             w_load_bad;

    // Next-count, boundary reload and load-validity decode.
    always_comb begin
        w_wrap     = 1'b0;
        w_apply    = 1'b0;
        w_div_nx   = r_div_cur;
        w_cnt_nx   = r_cnt;
        w_high     = L_ZERO;
        w_load_ok  = 1'b0;
        w_load_bad = 1'b0;

        w_wrap  = (r_cnt == (r_div_cur - L_ONE));
        w_apply = w_wrap && r_load_pend;

        if (w_apply) begin
            w_div_nx = r_pend;
        end else begin
            w_div_nx = r_div_cur;
        end

        if (w_wrap) begin
            w_cnt_nx = L_ZERO;
        end else begin
            w_cnt_nx = r_cnt + L_ONE;
        end

        // High length follows the divisor of the period being entered.
        w_high = f_high_len(w_div_nx);

        if (div_load) begin
            w_load_ok  = (div_val >= L_TWO);
            w_load_bad = (div_val < L_TWO);
        end else begin
            w_load_ok  = 1'b0;
            w_load_bad = 1'b0;
        end
    end

    // Counter, divisor in force and rising-edge waveform registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= L_CNT_RST;
            r_div_cur  <= L_DIV_RST;
            r_po_clk_q <= 1'b0;
            r_po_tick  <= 1'b0;
        end else if (en) begin
            r_cnt      <= w_cnt_nx;
            r_div_cur  <= w_div_nx;
            r_po_clk_q <= (w_cnt_nx < w_high);
            r_po_tick  <= (w_cnt_nx == L_ZERO);
        end else begin
            r_po_tick  <= 1'b0;
        end
    end

    // Pending-load bookkeeping; a new load outranks the clear at a wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= L_ZERO;
            r_load_pend <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_load_err <= w_load_bad;
            if (w_load_ok) begin
                r_pend      <= div_val;
                r_load_pend <= 1'b1;
            end else if (en && w_apply) begin
                r_load_pend <= 1'b0;
            end else begin
                r_load_pend <= r_load_pend;
            end
        end
    end

`ifdef CLK_DIV_ODD_DUTY_EN
    logic r_po_clk_n;

    // Half-cycle extension of the high phase for odd divisors.
    always_ff @(negedge clk) begin
        if (rst) begin
            r_po_clk_n <= 1'b0;
        end else if (r_div_cur[0]) begin
            r_po_clk_n <= r_po_clk_q;
        end else begin
            r_po_clk_n <= 1'b0;
        end
    end

    assign po_clk = r_po_clk_q | r_po_clk_n;
`else
    assign po_clk = r_po_clk_q;
`endif

    assign po_tick   = r_po_tick;
    assign load_err  = r_load_err;
    assign load_pend = r_load_pend;
    assign div_cur   = r_div_cur;

endmodule
